// File: rtl/clock3_pkg.sv
// clock3_pkg: shared types, constants and helpers for the clock3 time-of-day core.
// Holds BCD field limits, active-low 7-seg codes, alarm FSM state type and load check.
package clock3_pkg;

  localparam int DIGIT_W = 4;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Terminal counts of each two-digit BCD field
  localparam logic [DIGIT_W-1:0] SECS_MSB_TC = 4'd5;
  localparam logic [DIGIT_W-1:0] SECS_LSB_TC = 4'd9;
  localparam logic [DIGIT_W-1:0] MINS_MSB_TC = 4'd5;
  localparam logic [DIGIT_W-1:0] MINS_LSB_TC = 4'd9;
  localparam logic [DIGIT_W-1:0] HRS_MSB_TC  = 4'd2;
  localparam logic [DIGIT_W-1:0] HRS_LSB_TC  = 4'd3;

  typedef enum logic {
    A_IDLE,
    A_RING
  } alarm_st_t;

  function automatic logic [6:0] seg7(
    input logic [DIGIT_W-1:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // value is {hh_msb,hh_lsb,mm_msb,mm_lsb}, 24-hour form
  function automatic logic hhmm_valid(
    input logic [15:0] v
  );
    logic dig_ok;
    logic hh_ok;
    logic mm_ok;
    dig_ok = (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9)
          && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    hh_ok  = (v[15:12] < 4'd2)
          || ((v[15:12] == 4'd2) && (v[11:8] <= 4'd3));
    mm_ok  = (v[7:4] <= 4'd5);
    return dig_ok && hh_ok && mm_ok;
  endfunction

endpackage

// File: rtl/clock3_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping from {MSB_TC,LSB_TC} to 00.
// Ports: clk_i, rst_i, en_i (advance), load_i/load_val_i (overrides en_i),
//  q_o (count), q_nxt_o (value after this edge), carry_o (wrap this cycle).
module bcd_mod_counter
  import clock3_pkg::*;
#(
  parameter logic [3:0] MSB_TC = 4'd5,
  parameter logic [3:0] LSB_TC = 4'd9
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] q_o,
  output logic [7:0] q_nxt_o,
  output logic       carry_o
);

  logic [7:0] r_q;
  logic [7:0] w_inc;
  logic [7:0] w_nxt;
  logic       w_at_tc;

  assign w_at_tc = (r_q == {MSB_TC, LSB_TC});
  assign carry_o = en_i & w_at_tc & ~load_i;

  always_comb begin
    w_inc = r_q;
    if (w_at_tc) begin
      w_inc = 8'h00;
    end else if (r_q[3:0] == 4'd9) begin
      w_inc = {r_q[7:4] + 4'd1, 4'd0};
    end else begin
      w_inc = {r_q[7:4], r_q[3:0] + 4'd1};
    end
  end

  always_comb begin
    w_nxt = r_q;
    if (load_i) begin
      w_nxt = load_val_i;
    end else if (en_i) begin
      w_nxt = w_inc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= 8'h00;
    end else begin
      r_q <= w_nxt;
    end
  end

  assign q_o     = r_q;
  assign q_nxt_o = w_nxt;

endmodule

// File: rtl/clock3.sv
// clock3: BCD time-of-day core with prescaler, validated load, alarm, 12/24h display.
// Ports: clk_i, rst_i, load_i, load_alarm_i, value_i, mode12_i, blank_i, alarm_en_i
//  in; six active-low 7-seg digits HH:MM:SS, pm_o, alarm_o, err_o out.
module clock3 #(
  parameter int TICK_TC_P    = 49_999_999,
  parameter int ALARM_SECS_P = 30
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        load_alarm_i,
  input  logic [15:0] value_i,
  input  logic        mode12_i,
  input  logic        blank_i,
  input  logic        alarm_en_i,
  output logic [6:0]  hrs_msb_o,
  output logic [6:0]  hrs_lsb_o,
  output logic [6:0]  mins_msb_o,
  output logic [6:0]  mins_lsb_o,
  output logic [6:0]  secs_msb_o,
  output logic [6:0]  secs_lsb_o,
  output logic        pm_o,
  output logic        alarm_o,
  output logic        err_o
);

  import clock3_pkg::*;

  localparam int PW =
    (TICK_TC_P > 0) ? $clog2(TICK_TC_P + 1) : 1;
  localparam logic [PW-1:0] PRESC_TC  = PW'(TICK_TC_P);
  localparam logic [7:0]    RING_LAST = 8'(ALARM_SECS_P - 1);

  // Load button: 2-flop sync, then one more flop for edge detect
  logic r_load_s1;
  logic r_load_s2;
  logic r_load_s3;
  logic r_load_pulse;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_load_s1    <= 1'b0;
      r_load_s2    <= 1'b0;
      r_load_s3    <= 1'b0;
      r_load_pulse <= 1'b0;
    end else begin
      r_load_s1    <= load_i;
      r_load_s2    <= r_load_s1;
      r_load_s3    <= r_load_s2;
      r_load_pulse <= r_load_s2 & ~r_load_s3;
    end
  end

  logic w_valid;
  logic w_time_load;
  logic w_alarm_load;

  assign w_valid      = hhmm_valid(value_i);
  assign w_time_load  = r_load_pulse & w_valid & ~load_alarm_i;
  assign w_alarm_load = r_load_pulse & w_valid & load_alarm_i;
  assign err_o        = r_load_pulse & ~w_valid;

  // Prescaler; a time load restarts the second
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PRESC_TC);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_presc <= '0;
    end else if (w_time_load || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Time counters; a time load swallows a coincident tick
  logic [7:0] w_secs;
  logic [7:0] w_mins;
  logic [7:0] w_hrs;
  logic [7:0] w_secs_nxt;
  logic [7:0] w_mins_nxt;
  logic [7:0] w_hrs_nxt;
  logic       w_secs_en;
  logic       w_secs_carry;
  logic       w_mins_carry;
  logic       w_hrs_carry;
  logic       w_unused_day_wrap;

  assign w_secs_en         = w_tick & ~w_time_load;
  assign w_unused_day_wrap = w_hrs_carry;

  bcd_mod_counter #(
    .MSB_TC (SECS_MSB_TC),
    .LSB_TC (SECS_LSB_TC)
  ) u_secs (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (w_secs_en),
    .load_i     (w_time_load),
    .load_val_i (8'h00),
    .q_o        (w_secs),
    .q_nxt_o    (w_secs_nxt),
    .carry_o    (w_secs_carry)
  );

  bcd_mod_counter #(
    .MSB_TC (MINS_MSB_TC),
    .LSB_TC (MINS_LSB_TC)
  ) u_mins (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (w_secs_carry),
    .load_i     (w_time_load),
    .load_val_i (value_i[7:0]),
    .q_o        (w_mins),
    .q_nxt_o    (w_mins_nxt),
    .carry_o    (w_mins_carry)
  );

  bcd_mod_counter #(
    .MSB_TC (HRS_MSB_TC),
    .LSB_TC (HRS_LSB_TC)
  ) u_hrs (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (w_mins_carry),
    .load_i     (w_time_load),
    .load_val_i (value_i[15:8]),
    .q_o        (w_hrs),
    .q_nxt_o    (w_hrs_nxt),
    .carry_o    (w_hrs_carry)
  );

  // Alarm store and match; only a counted tick into hh:mm:00 can match
  logic [15:0] r_alarm_hhmm;
  logic        w_match;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alarm_hhmm <= 16'h0000;
    end else if (w_alarm_load) begin
      r_alarm_hhmm <= value_i;
    end
  end

  assign w_match = alarm_en_i & w_secs_carry
                 & (w_secs_nxt == 8'h00)
                 & ({w_hrs_nxt, w_mins_nxt} == r_alarm_hhmm);

  alarm_st_t  r_alarm_st;
  logic [7:0] r_ring_cnt;
  logic       r_alarm;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alarm_st <= A_IDLE;
      r_ring_cnt <= 8'd0;
      r_alarm    <= 1'b0;
    end else if (!alarm_en_i || w_time_load) begin
      r_alarm_st <= A_IDLE;
      r_ring_cnt <= 8'd0;
      r_alarm    <= 1'b0;
    end else begin
      case (r_alarm_st)
        A_IDLE: begin
          if (w_match) begin
            r_alarm_st <= A_RING;
            r_ring_cnt <= 8'd0;
            r_alarm    <= 1'b1;
          end
        end
        A_RING: begin
          if (w_tick) begin
            if (r_ring_cnt == RING_LAST) begin
              r_alarm_st <= A_IDLE;
              r_alarm    <= 1'b0;
            end else begin
              r_ring_cnt <= r_ring_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign alarm_o = r_alarm;

  // Hour mapping: BCD to binary, optional 12h fold, back to two digits
  logic [4:0] w_hr_bin;
  logic [4:0] w_hr_disp;
  logic [3:0] w_hr_tens;
  logic [3:0] w_hr_ones;
  logic       w_pm;

  assign w_hr_bin = {w_hrs[5:4], 3'b000}
                  + {2'b00, w_hrs[5:4], 1'b0}
                  + {1'b0, w_hrs[3:0]};
  assign w_pm     = (w_hr_bin >= 5'd12);

  always_comb begin
    w_hr_disp = w_hr_bin;
    if (mode12_i) begin
      if (w_hr_bin == 5'd0) begin
        w_hr_disp = 5'd12;
      end else if (w_hr_bin > 5'd12) begin
        w_hr_disp = w_hr_bin - 5'd12;
      end
    end
    w_hr_tens = 4'd0;
    w_hr_ones = w_hr_disp[3:0];
    if (w_hr_disp >= 5'd20) begin
      w_hr_tens = 4'd2;
      w_hr_ones = 4'(w_hr_disp - 5'd20);
    end else if (w_hr_disp >= 5'd10) begin
      w_hr_tens = 4'd1;
      w_hr_ones = 4'(w_hr_disp - 5'd10);
    end
  end

  // Display register stage
  logic [6:0] r_hrs_msb;
  logic [6:0] r_hrs_lsb;
  logic [6:0] r_mins_msb;
  logic [6:0] r_mins_lsb;
  logic [6:0] r_secs_msb;
  logic [6:0] r_secs_lsb;
  logic       r_pm;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hrs_msb  <= SEG_0;
      r_hrs_lsb  <= SEG_0;
      r_mins_msb <= SEG_0;
      r_mins_lsb <= SEG_0;
      r_secs_msb <= SEG_0;
      r_secs_lsb <= SEG_0;
      r_pm       <= 1'b0;
    end else begin
      r_hrs_msb  <= (blank_i && (w_hr_tens == 4'd0))
                    ? SEG_BLANK : seg7(w_hr_tens);
      r_hrs_lsb  <= seg7(w_hr_ones);
      r_mins_msb <= seg7(w_mins[7:4]);
      r_mins_lsb <= seg7(w_mins[3:0]);
      r_secs_msb <= seg7(w_secs[7:4]);
      r_secs_lsb <= seg7(w_secs[3:0]);
      r_pm       <= w_pm;
    end
  end

  assign hrs_msb_o  = r_hrs_msb;
  assign hrs_lsb_o  = r_hrs_lsb;
  assign mins_msb_o = r_mins_msb;
  assign mins_lsb_o = r_mins_lsb;
  assign secs_msb_o = r_secs_msb;
  assign secs_lsb_o = r_secs_lsb;
  assign pm_o       = r_pm;

endmodule

// File: tb/tb_clock3.sv
// tb_clock3: directed plus random stimulus for clock3, checked against a
// seconds-of-day reference model with immediate assertions.
module tb_clock3;

  localparam int TC    = 9;
  localparam int ASECS = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load;
  logic        load_alarm;
  logic [15:0] value;
  logic        mode12;
  logic        blank;
  logic        alarm_en;
  logic [6:0]  hrs_msb, hrs_lsb, mins_msb, mins_lsb, secs_msb, secs_lsb;
  logic        pm, alarm, err;

  clock3 #(
    .TICK_TC_P    (TC),
    .ALARM_SECS_P (ASECS)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (load),
    .load_alarm_i (load_alarm),
    .value_i      (value),
    .mode12_i     (mode12),
    .blank_i      (blank),
    .alarm_en_i   (alarm_en),
    .hrs_msb_o    (hrs_msb),
    .hrs_lsb_o    (hrs_lsb),
    .mins_msb_o   (mins_msb),
    .mins_lsb_o   (mins_lsb),
    .secs_msb_o   (secs_msb),
    .secs_lsb_o   (secs_lsb),
    .pm_o         (pm),
    .alarm_o      (alarm),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model: time as seconds of day, alarm as minute of day
  int m_tod, m_presc, m_ring, m_alarm_min;
  int d_tod;
  bit d_mode12, d_blank;
  bit m_err_exp;

  task automatic check(input string tag, input logic [6:0] obs,
                       input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_valid(input logic [15:0] v,
                                  output int hh, output int mm);
    int d3, d2, d1, d0;
    d3 = int'(v[15:12]); d2 = int'(v[11:8]);
    d1 = int'(v[7:4]);   d0 = int'(v[3:0]);
    hh = d3 * 10 + d2;
    mm = d1 * 10 + d0;
    return d3 <= 9 && d2 <= 9 && d1 <= 9 && d0 <= 9
        && hh <= 23 && mm <= 59;
  endfunction

  task automatic check_outputs();
    int h, mi, s, dh;
    h  = d_tod / 3600;
    mi = (d_tod / 60) % 60;
    s  = d_tod % 60;
    dh = h;
    if (d_mode12) begin
      if (h == 0) dh = 12;
      else if (h > 12) dh = h - 12;
    end
    check("hrs_msb", hrs_msb,
          (d_blank && dh / 10 == 0) ? 7'h7F : seg_tab[dh / 10]);
    check("hrs_lsb", hrs_lsb, seg_tab[dh % 10]);
    check("mins_msb", mins_msb, seg_tab[mi / 10]);
    check("mins_lsb", mins_lsb, seg_tab[mi % 10]);
    check("secs_msb", secs_msb, seg_tab[s / 10]);
    check("secs_lsb", secs_lsb, seg_tab[s % 10]);
    check("pm", 7'(pm), 7'(h >= 12));
    check("alarm", 7'(alarm), 7'(m_ring > 0));
    check("err", 7'(err), 7'(m_err_exp));
  endtask

  task automatic check_reset_vals();
    check("rst_hrs_msb", hrs_msb, 7'h40);
    check("rst_hrs_lsb", hrs_lsb, 7'h40);
    check("rst_mins_msb", mins_msb, 7'h40);
    check("rst_mins_lsb", mins_lsb, 7'h40);
    check("rst_secs_msb", secs_msb, 7'h40);
    check("rst_secs_lsb", secs_lsb, 7'h40);
    check("rst_pm", 7'(pm), 7'h0);
    check("rst_alarm", 7'(alarm), 7'h0);
  endtask

  task automatic model_reset();
    m_tod = 0; m_presc = 0; m_ring = 0; m_alarm_min = 0;
    d_tod = 0; d_mode12 = 0; d_blank = 0; m_err_exp = 0;
  endtask

  // One clock: apply_load = load pulse acts at this edge;
  // pulse_next = load pulse is visible after this edge
  task automatic step(input bit apply_load, input bit pulse_next);
    bit tick, ok, tload, aload;
    int hh, mm, old_amin;
    ok    = tb_valid(value, hh, mm);
    tick  = (m_presc == TC);
    tload = apply_load && ok && !load_alarm;
    aload = apply_load && ok && load_alarm;
    old_amin = m_alarm_min;
    @(posedge clk);
    d_tod = m_tod; d_mode12 = mode12; d_blank = blank;
    if (tload) begin
      m_tod = hh * 3600 + mm * 60;
      m_presc = 0;
    end else if (tick) begin
      m_presc = 0;
      m_tod = (m_tod + 1) % 86400;
    end else begin
      m_presc++;
    end
    if (aload) m_alarm_min = hh * 60 + mm;
    if (!alarm_en || tload) m_ring = 0;
    else if (m_ring > 0) begin
      if (tick) m_ring--;
    end else if (tick && m_tod % 60 == 0 && m_tod / 60 == old_amin)
      m_ring = ASECS;
    m_err_exp = pulse_next && !ok;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic do_load(input bit is_alarm, input logic [15:0] v);
    load_alarm = is_alarm;
    value = v;
    load = 1'b1;
    step(0, 0);
    step(0, 0);
    step(0, 1);
    step(1, 0);
    load = 1'b0;
    run(3);
  endtask

  task automatic align_presc(input int p);
    for (int i = 0; i < 2 * (TC + 1) && m_presc != p; i++) step(0, 0);
    check("align", 7'(m_presc == p), 7'h1);
  endtask

  initial begin
    int high;
    int hh, mm;
    logic [15:0] v;
    load = 0; load_alarm = 0; value = 0;
    mode12 = 0; blank = 0; alarm_en = 0;

    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    model_reset();
    run(25);

    // asynchronous reset mid-count
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    model_reset();

    // day wrap
    do_load(0, 16'h2359);
    run(600);

    // 12-hour display with blanking
    mode12 = 1; blank = 1;
    do_load(0, 16'h1305);
    run(5);
    do_load(0, 16'h0030);
    run(5);
    do_load(0, 16'h1200);
    run(5);

    // rejected loads
    do_load(0, 16'h2460);
    do_load(0, 16'h1A00);
    run(5);

    // alarm rings for exactly ASECS ticks
    mode12 = 0; blank = 0; alarm_en = 1;
    do_load(1, 16'h0001);
    do_load(0, 16'h0000);
    high = 0;
    for (int i = 0; i < 1000; i++) begin
      step(0, 0);
      if (alarm === 1'b1) high++;
    end
    checks++;
    assert (high == ASECS * (TC + 1)) else begin
      errors++;
      $error("FAIL alarm_len: observed %0d expected %0d",
             high, ASECS * (TC + 1));
    end

    // disarm mid-ring
    do_load(0, 16'h0000);
    run(700);
    check("ring_mid", 7'(alarm), 7'h1);
    alarm_en = 0;
    step(0, 0);
    check("disarm", 7'(alarm), 7'h0);
    alarm_en = 1;
    run(50);

    // time load coincident with tick, then alarm load with tick
    align_presc(6);
    do_load(0, 16'h0712);
    run(12);
    align_presc(6);
    do_load(1, 16'h0713);
    run(70);

    // random loads and modes
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        hh = int'($urandom_range(0, 23));
        mm = int'($urandom_range(0, 59));
        v = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
      end else begin
        v = 16'($urandom);
      end
      mode12   = 1'($urandom_range(0, 1));
      blank    = 1'($urandom_range(0, 1));
      alarm_en = 1'($urandom_range(0, 1));
      do_load(1'($urandom_range(0, 1)), v);
      run(int'($urandom_range(0, 40)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
